// File: rtl/lzc_share_pkg.sv
// Shared constants and width helpers for the lzc_share_arbiter slice.
package lzc_share_pkg;

  // Pipeline stage-valid encoding
  localparam logic STAGE_EMPTY = 1'b0;
  localparam logic STAGE_FULL  = 1'b1;

  // Width of the statistics counter port
  localparam int unsigned STAT_W = 16;

  // Index width for n items, never below one bit (used for resp_id and resp_p)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lzc_share_arbiter_if.sv
// Request/response bus of the shared LZC arbiter; master drives requests, slave is the arbiter.
interface lzc_share_arbiter_if #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned NREQ  = 2
);
  import lzc_share_pkg::*;

  localparam int unsigned ID_W = idx_width(NREQ);
  localparam int unsigned P_W  = idx_width(WIDTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [P_W-1:0]        resp_p;
  logic                  resp_v;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_p, resp_v
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_p, resp_v
  );

endinterface

// File: rtl/lzc_2bitaligned_bigendian.sv
// Combinational leading-zero counter built on 2-bit aligned groups, MSB first.
// Zero input gives v_c=0 and p_c=0.
module lzc_2bitaligned_bigendian
  import lzc_share_pkg::*;
#(
  parameter int unsigned WIDTH = 28
) (
  input  logic [WIDTH-1:0]                data,
  output logic [idx_width(WIDTH)-1:0]     p_c,
  output logic                            v_c
);

  localparam int unsigned P_W   = idx_width(WIDTH);
  localparam int unsigned NPAIR = WIDTH / 2;

  logic [1:0] pair;

  // Scan pairs from the LSB end so the most significant nonzero pair wins
  always_comb begin
    p_c  = '0;
    v_c  = 1'b0;
    pair = '0;
    for (int unsigned i = 0; i < NPAIR; i++) begin
      pair = 2'(data >> (2 * i));
      if (pair != 2'b00) begin
        v_c = 1'b1;
        p_c = P_W'(2 * (NPAIR - 1 - i) + (pair[1] ? 0 : 1));
      end
    end
  end

endmodule

// File: rtl/lzc_share_arbiter.sv
// Round-robin arbiter sharing one LZC among NREQ requesters via a two-stage pipeline.
// S1 holds operand + id; S2 holds the registered result.
// Optional feature: define LZC_SHARE_STATS_EN to add the saturating stat_count port.
module lzc_share_arbiter
  import lzc_share_pkg::*;
#(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned NREQ  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lzc_share_arbiter_if.slave   bus
`ifdef LZC_SHARE_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_count
`endif
);

  localparam int unsigned ID_W = idx_width(NREQ);
  localparam int unsigned P_W  = idx_width(WIDTH);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [ID_W-1:0]  s1_id_q;
  logic             s2_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [P_W-1:0]   resp_p_q;
  logic             resp_v_q;
  logic [ID_W-1:0]  ptr_q;

  logic             load2;
  logic             s1_can;
  logic             accept;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] grant_data;
  logic [NREQ-1:0]  req_ready_c;
  logic [P_W-1:0]   lzc_p;
  logic             lzc_v;

  // The single shared LZC, fed from the S1 operand register
  lzc_2bitaligned_bigendian #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .data (s1_data_q),
    .p_c  (lzc_p),
    .v_c  (lzc_v)
  );

  // Pipeline advance conditions
  assign load2  = (s2_valid_q == STAGE_EMPTY) || bus.resp_ready;
  assign s1_can = (s1_valid_q == STAGE_EMPTY) || load2;

  // Round-robin search starting at the pointer; idle requesters are skipped
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && 1'(bus.req_valid >> ((32'(ptr_q) + k) % NREQ))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign accept     = rst_n && s1_can && grant_found;
  assign grant_data = WIDTH'(bus.req_data >> (32'(grant_id) * WIDTH));

  // One-hot ready for the granted requester only
  always_comb begin
    req_ready_c = '0;
    if (accept) begin
      req_ready_c = NREQ'(1) << grant_id;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = s2_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_p     = resp_p_q;
  assign bus.resp_v     = resp_v_q;

  // Stage registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= STAGE_EMPTY;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= STAGE_EMPTY;
      resp_id_q  <= '0;
      resp_p_q   <= '0;
      resp_v_q   <= 1'b0;
      ptr_q      <= '0;
    end else begin
      if (load2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q == STAGE_FULL) begin
          resp_id_q <= s1_id_q;
          resp_p_q  <= lzc_p;
          resp_v_q  <= lzc_v;
        end
      end
      if (accept) begin
        s1_valid_q <= STAGE_FULL;
        s1_data_q  <= grant_data;
        s1_id_q    <= grant_id;
        ptr_q      <= ID_W'((32'(grant_id) + 1) % NREQ);
      end else if (load2) begin
        s1_valid_q <= STAGE_EMPTY;
      end
    end
  end

`ifdef LZC_SHARE_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of accepted transfers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (accept && (stat_q != '1)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign stat_count = stat_q;
`endif

endmodule
